// File: rtl/mux_arb_n_to_1_if.sv
// Request/response bundle for mux_arb_n_to_1: NUM_IN flattened request channels in,
// one registered channel out, plus the arbitration-mode controls.
interface mux_arb_n_to_1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = 2
) ();
  logic [1:0]                     mode;
  logic [SEL_WIDTH-1:0]           force_sel;
  logic [NUM_IN*DATA_WIDTH-1:0]   in_data;
  logic [NUM_IN-1:0]              in_valid;
  logic [NUM_IN-1:0]              in_last;
  logic [NUM_IN-1:0]              in_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_last;
  logic [SEL_WIDTH-1:0]           out_sel;
  logic                           out_ready;

  // Driver side: sources the request channels and the downstream ready.
  modport master (
    output mode, force_sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );

  // Arbiter side.
  modport slave (
    input  mode, force_sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/mux_arb_n_to_1.sv
// N-to-1 registered arbitrated selector: fixed-priority, round-robin or forced select,
// with packet lock held from the first word of a packet until its last word.
module mux_arb_n_to_1 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,   // 2..16
  parameter int SEL_WIDTH  = 2    // ceil(log2(NUM_IN))
) (
  input  logic              clk,
  input  logic              reset_n,
  mux_arb_n_to_1_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_FIXED = 2'b00,
    MODE_RR    = 2'b01,
    MODE_FORCE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  logic [DATA_WIDTH-1:0] ch_data [NUM_IN];
  logic [NUM_IN-1:0]     grant_oh;
  logic                  grant_vld;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  can_load;
  logic                  in_xfer;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;
  logic                  lock_q,      lock_d;
  logic [SEL_WIDTH-1:0]  lock_idx_q,  lock_idx_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
      assign ch_data[gi]  = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign grant_oh[gi] = grant_vld && (grant_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  assign can_load     = ~out_valid_q | bus.out_ready;
  assign in_xfer      = grant_vld & can_load;
  // Gated by reset so no channel sees ready while the arbiter is held in reset.
  assign bus.in_ready = grant_oh & {NUM_IN{can_load & reset_n}};

  // Grant search; descending loops let the lowest qualifying index win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (lock_q) begin
      for (int j = NUM_IN - 1; j >= 0; j--) begin
        if (bus.in_valid[j] && (SEL_WIDTH'(j) == lock_idx_q)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_WIDTH'(j);
        end
      end
    end else begin
      case (bus.mode)
        MODE_RR: begin
          for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (bus.in_valid[j] && (SEL_WIDTH'(j) >= rr_ptr_q)) begin
              grant_vld = 1'b1;
              grant_idx = SEL_WIDTH'(j);
            end
          end
          // Nothing at or above the pointer: wrap to the bottom.
          if (!grant_vld) begin
            for (int j = NUM_IN - 1; j >= 0; j--) begin
              if (bus.in_valid[j]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_WIDTH'(j);
              end
            end
          end
        end
        MODE_FORCE: begin
          for (int j = 0; j < NUM_IN; j++) begin
            if (bus.in_valid[j] && (SEL_WIDTH'(j) == bus.force_sel)) begin
              grant_vld = 1'b1;
              grant_idx = SEL_WIDTH'(j);
            end
          end
        end
        default: begin
          for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (bus.in_valid[j]) begin
              grant_vld = 1'b1;
              grant_idx = SEL_WIDTH'(j);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (SEL_WIDTH'(j) == grant_idx) begin
        sel_data = ch_data[j];
        sel_last = bus.in_last[j];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_sel_d   = grant_idx;
      lock_d      = ~sel_last;
      lock_idx_d  = grant_idx;
      // Round-robin fairness is per packet, so the pointer moves only on a last word.
      if ((bus.mode == MODE_RR) && sel_last) begin
        rr_ptr_d = (grant_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1: expected output words are queued as stimulus is
// driven and compared in order whenever the output channel completes a transfer.
module tb_mux_arb_n_to_1;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mux_arb_n_to_1_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(SW)) bus ();

  mux_arb_n_to_1 #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(SW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Leaves the caller 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] d, input logic v, input logic l);
    bus.in_data[i*DW +: DW] = d;
    bus.in_valid[i]         = v;
    bus.in_last[i]          = l;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic [SW-1:0] s);
    exp_t e;
    e.data = d;
    e.last = l;
    e.sel  = s;
    sb.push_back(e);
  endtask

  task automatic drain();
    bus.in_valid = '0;
    repeat (2) cyc();
  endtask

  // Inputs change just after rising edges, so the falling edge sees settled values.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n === 1'b1) begin
      check_val("ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_word", 64'(bus.out_data), 64'hDEAD_0000);
        end else begin
          e = sb.pop_front();
          $display("out xfer: sel=%0d data=%h last=%0b (want sel=%0d data=%h last=%0b)",
                   bus.out_sel, bus.out_data, bus.out_last, e.sel, e.data, e.last);
          check_val("sb_data", 64'(bus.out_data), 64'(e.data));
          check_val("sb_sel",  64'(bus.out_sel),  64'(e.sel));
          check_val("sb_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n       = 1'b0;
    bus.mode      = 2'b00;
    bus.force_sel = '0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;

    // Reset state, with every channel requesting.
    repeat (2) cyc();
    bus.in_valid = '1;
    #1;
    check_val("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data",  64'(bus.out_data),  64'd0);
    check_val("rst_out_last",  64'(bus.out_last),  64'd0);
    check_val("rst_out_sel",   64'(bus.out_sel),   64'd0);
    bus.in_valid = '0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Fixed priority: ch1 before ch3, back to back.
    bus.mode = 2'b00;
    bus.out_ready = 1'b1;
    set_ch(1, 32'h11, 1'b1, 1'b1);
    set_ch(3, 32'h33, 1'b1, 1'b1);
    push_exp(32'h11, 1'b1, 2'd1);
    push_exp(32'h33, 1'b1, 2'd3);
    #1 check_val("fp_ready0", 64'(bus.in_ready), 64'b0010);
    cyc();
    set_ch(1, 32'h11, 1'b0, 1'b1);
    check_val("fp_valid1", 64'(bus.out_valid), 64'd1);
    check_val("fp_data1",  64'(bus.out_data),  64'h11);
    #1 check_val("fp_ready1", 64'(bus.in_ready), 64'b1000);
    cyc();
    set_ch(3, 32'h33, 1'b0, 1'b1);
    check_val("fp_valid2", 64'(bus.out_valid), 64'd1);
    check_val("fp_sel2",   64'(bus.out_sel),   64'd3);
    cyc();
    check_val("fp_idle", 64'(bus.out_valid), 64'd0);

    // Round-robin with all channels continuously requesting.
    bus.mode = 2'b01;
    for (int i = 0; i < NI; i++) set_ch(i, DW'(32'hA0 + i), 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) push_exp(DW'(32'hA0 + rr_exp[k]), 1'b1, SW'(rr_exp[k]));
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_val("rr_sel", 64'(bus.out_sel), 64'(rr_exp[k]));
    end
    drain();
    check_val("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Round-robin packet lock: ch2 sends 3 words while ch0 waits (pointer is now 1).
    set_ch(0, 32'hC0, 1'b1, 1'b1);
    for (int w = 1; w <= 3; w++) begin
      set_ch(2, DW'(32'h200 + w), 1'b1, (w == 3));
      push_exp(DW'(32'h200 + w), (w == 3), 2'd2);
      #1 check_val("lock_ready", 64'(bus.in_ready), 64'b0100);
      cyc();
    end
    set_ch(2, 32'h0, 1'b0, 1'b0);
    push_exp(32'hC0, 1'b1, 2'd0);
    #1 check_val("unlock_ready", 64'(bus.in_ready), 64'b0001);
    cyc();
    check_val("unlock_sel", 64'(bus.out_sel), 64'd0);
    drain();

    // Backpressure: hold the loaded word, then refill in the same cycle it drains.
    bus.mode = 2'b00;
    bus.out_ready = 1'b0;
    set_ch(1, 32'h111, 1'b1, 1'b1);
    push_exp(32'h111, 1'b1, 2'd1);
    #1 check_val("bp_ready_empty", 64'(bus.in_ready), 64'b0010);
    cyc();
    set_ch(1, 32'h112, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 check_val("bp_ready_full", 64'(bus.in_ready), 64'd0);
      check_val("bp_hold_data", 64'(bus.out_data), 64'h111);
      check_val("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      if (k < 2) cyc();
    end
    bus.out_ready = 1'b1;
    push_exp(32'h112, 1'b1, 2'd1);
    #1 check_val("bp_ready_release", 64'(bus.in_ready), 64'b0010);
    cyc();
    set_ch(1, 32'h0, 1'b0, 1'b0);
    check_val("bp_refill", 64'(bus.out_data), 64'h112);
    drain();

    // Forced select: channel 3 chosen while only ch0 requests, then ch3 arrives.
    bus.mode = 2'b10;
    bus.force_sel = 2'd3;
    set_ch(0, 32'h5, 1'b1, 1'b1);
    #1 check_val("fs_no_grant", 64'(bus.in_ready), 64'd0);
    repeat (2) begin
      cyc();
      check_val("fs_idle", 64'(bus.out_valid), 64'd0);
    end
    set_ch(3, 32'hABCD, 1'b1, 1'b1);
    push_exp(32'hABCD, 1'b1, 2'd3);
    #1 check_val("fs_ready", 64'(bus.in_ready), 64'b1000);
    cyc();
    check_val("fs_data", 64'(bus.out_data), 64'hABCD);
    check_val("fs_sel",  64'(bus.out_sel),  64'd3);
    drain();

    // Reset in the middle of a locked packet with a word buffered.
    bus.mode = 2'b00;
    bus.out_ready = 1'b0;
    set_ch(2, 32'h77, 1'b1, 1'b0);
    cyc();
    check_val("mid_valid", 64'(bus.out_valid), 64'd1);
    check_val("mid_last",  64'(bus.out_last),  64'd0);
    set_ch(0, 32'h99, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    #1 check_val("mid_lock_ready", 64'(bus.in_ready), 64'b0100);
    #1 reset_n = 1'b0;
    #1;
    check_val("async_valid", 64'(bus.out_valid), 64'd0);
    check_val("async_data",  64'(bus.out_data),  64'd0);
    check_val("async_ready", 64'(bus.in_ready),  64'd0);
    set_ch(2, 32'h0, 1'b0, 1'b0);
    cyc();
    reset_n = 1'b1;
    push_exp(32'h99, 1'b1, 2'd0);
    #1 check_val("post_rst_ready", 64'(bus.in_ready), 64'b0001);
    cyc();
    check_val("post_rst_sel",  64'(bus.out_sel),  64'd0);
    check_val("post_rst_data", 64'(bus.out_data), 64'h99);
    drain();

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
